// File: rtl/ring_mem_requester_pkg.sv
// ============================================================================
//  Module      : ring_mem_requester_pkg
//  Description : Shared slot encodings, address-word layout and line geometry
//                for ring memory clients.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_mem_requester_pkg;

    localparam logic [3:0] SLOT_NULL      = 4'd0;
    localparam logic [3:0] SLOT_TOKEN     = 4'd1;
    localparam logic [3:0] SLOT_ADDRESS   = 4'd2;
    localparam logic [3:0] SLOT_WRITEDATA = 4'd3;
    localparam logic [3:0] SLOT_DMCADDR   = 4'd4;
    localparam logic [3:0] SLOT_DMCDATA   = 4'd5;

    localparam int READ_BIT       = 28;
    localparam int ADDR_MSB       = 27;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;

    typedef struct packed {
        logic [3:0]        stype;
        logic [3:0]        src;
        logic [WORD_W-1:0] data;
    } slot_t;

    function automatic slot_t mk_slot(input logic [3:0] stype, input logic [3:0] src,
                                      input logic [WORD_W-1:0] data);
        slot_t s;
        s.stype = stype;
        s.src   = src;
        s.data  = data;
        return s;
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic rd, input logic [ADDR_MSB:0] addr);
        logic [WORD_W-1:0] w;
        w                = '0;
        w[READ_BIT]      = rd;
        w[ADDR_MSB:0]    = addr;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ring_mem_requester.sv
// ============================================================================
//  Module      : ring_mem_requester
//  Description : Ring station issuing one read / line-write at a time to the
//                ring memory controller and collecting read-return lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_mem_requester
    import ring_mem_requester_pkg::*;
#(
    parameter logic [3:0] CORE_ID    = 4'd1,
    parameter int         RD_TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WORD_W-1:0]   RingIn,
    input  logic [3:0]          SlotTypeIn,
    input  logic [3:0]          SourceIn,
    output logic [WORD_W-1:0]   RingOut,
    output logic [3:0]          SlotTypeOut,
    output logic [3:0]          SourceOut,
    input  logic [WORD_W-1:0]   RDreturn,
    input  logic [3:0]          RDdest,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_MSB:0]   req_addr,
    input  logic [LINE_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [LINE_W-1:0]   rsp_data,
    output logic                err
);

    localparam int               TMO_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RD_TIMEOUT - 1);
    localparam logic [1:0]       WCNT_LAST = 2'(WORDS_PER_LINE - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_TOKEN = 3'd1;
    localparam logic [2:0] ST_SEND_ADDR  = 3'd2;
    localparam logic [2:0] ST_SEND_WD    = 3'd3;
    localparam logic [2:0] ST_RELEASE    = 3'd4;
    localparam logic [2:0] ST_WAIT_RD    = 3'd5;

    logic [2:0]                    r_state;
    logic                          r_rdy_en;
    logic                          r_write;
    logic [ADDR_MSB:0]             r_addr;
    logic [3:0][WORD_W-1:0]        r_wdata;
    logic [3:0][WORD_W-1:0]        r_rline;
    logic [1:0]                    r_wcnt;
    logic [1:0]                    r_rcnt;
    logic [TMO_W-1:0]              r_tmo;
    slot_t                         r_out;
    logic                          r_rsp_valid;
    logic [LINE_W-1:0]             r_rsp_data;
    logic                          r_err;

    slot_t w_in;
    logic  w_hold;
    logic  w_rd_hit;
    logic  w_rd_done;

    assign w_in      = mk_slot(SlotTypeIn, SourceIn, RingIn);
    // While the token is held, nothing but Null may legally arrive.
    assign w_hold    = (r_state == ST_SEND_ADDR) || (r_state == ST_SEND_WD) ||
                       (r_state == ST_RELEASE);
    assign w_rd_hit  = (RDdest == CORE_ID);
    assign w_rd_done = w_rd_hit && (r_rcnt == WCNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rdy_en    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rline     <= '0;
            r_wcnt      <= 2'd0;
            r_rcnt      <= 2'd0;
            r_tmo       <= '0;
            r_out       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rdy_en    <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_out       <= w_in;
            if (w_hold && (SlotTypeIn != SLOT_NULL)) begin
                r_err <= 1'b1;
            end
            if (w_rd_hit && (r_state != ST_WAIT_RD)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_rdy_en) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= ST_WAIT_TOKEN;
                    end
                end
                ST_WAIT_TOKEN: begin
                    if (SlotTypeIn == SLOT_TOKEN) begin
                        r_out   <= mk_slot(SLOT_ADDRESS, CORE_ID, addr_word(!r_write, r_addr));
                        r_state <= ST_SEND_ADDR;
                    end
                end
                ST_SEND_ADDR: begin
                    if (r_write) begin
                        r_out   <= mk_slot(SLOT_WRITEDATA, CORE_ID, r_wdata[0]);
                        r_wcnt  <= 2'd0;
                        r_state <= ST_SEND_WD;
                    end else begin
                        r_out   <= mk_slot(SLOT_TOKEN, 4'd0, '0);
                        r_state <= ST_RELEASE;
                    end
                end
                ST_SEND_WD: begin
                    if (r_wcnt == WCNT_LAST) begin
                        r_out   <= mk_slot(SLOT_TOKEN, 4'd0, '0);
                        r_state <= ST_RELEASE;
                    end else begin
                        r_out  <= mk_slot(SLOT_WRITEDATA, CORE_ID, r_wdata[r_wcnt + 2'd1]);
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    r_out <= mk_slot(SLOT_NULL, 4'd0, '0);
                    if (r_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rcnt  <= 2'd0;
                        r_tmo   <= '0;
                        r_state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (w_rd_hit) begin
                        r_rline[r_rcnt] <= RDreturn;
                        r_rcnt          <= r_rcnt + 2'd1;
                    end
                    if (w_rd_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {RDreturn, r_rline[2:0]};
                        r_state     <= ST_IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RingOut     = r_out.data;
    assign SlotTypeOut = r_out.stype;
    assign SourceOut   = r_out.src;
    assign req_ready   = (r_state == ST_IDLE) && r_rdy_en;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ring_mem_requester.sv
// ============================================================================
//  Module      : tb_ring_mem_requester
//  Description : Self-checking bench with a slot-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_mem_requester;
    import ring_mem_requester_pkg::*;

    localparam logic [3:0] C_ID = 4'd1;
    localparam int         C_TO = 1024;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  RingIn = '0;
    logic [3:0]   SlotTypeIn = '0;
    logic [3:0]   SourceIn = '0;
    logic [31:0]  RingOut;
    logic [3:0]   SlotTypeOut;
    logic [3:0]   SourceOut;
    logic [31:0]  RDreturn = '0;
    logic [3:0]   RDdest = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [27:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         err;

    ring_mem_requester #(.CORE_ID(C_ID), .RD_TIMEOUT(C_TO)) u_dut (
        .clock(clock), .reset(reset),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .RDreturn(RDreturn), .RDdest(RDdest),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: token capture queues the whole burst, then drains it.
    typedef struct {
        logic [3:0]  t;
        logic [3:0]  s;
        logic [31:0] d;
    } slot_s;

    slot_s        m_q[$];
    logic [31:0]  m_words[$];
    bit           m_pend, m_isread, m_rd_active, m_hold;
    int           m_tmo;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;
    logic [31:0]  e_ring;
    logic [3:0]   e_type, e_src;
    logic         e_ready, e_rsp_valid, e_err;
    logic [127:0] e_rsp_data;

    task automatic model_reset();
        m_q.delete(); m_words.delete();
        m_pend = 0; m_isread = 0; m_rd_active = 0; m_hold = 0; m_tmo = 0;
        e_ring = '0; e_type = '0; e_src = '0;
        e_ready = 0; e_rsp_valid = 0; e_err = 0; e_rsp_data = '0;
    endtask

    task automatic model_step();
        bit    ready_pre = e_ready;
        bit    rd_pre    = m_rd_active;
        slot_s s;
        e_rsp_valid = 0;
        if (m_hold) begin
            if (SlotTypeIn != SLOT_NULL) e_err = 1;
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
                e_type = s.t; e_src = s.s; e_ring = s.d;
            end else begin
                e_type = '0; e_src = '0; e_ring = '0;
                m_hold = 0;
                if (m_isread) begin
                    m_rd_active = 1; m_words.delete(); m_tmo = 0;
                end else begin
                    m_pend = 0;
                end
            end
        end else if (m_pend && !m_rd_active && SlotTypeIn == SLOT_TOKEN) begin
            m_q.push_back('{SLOT_ADDRESS, C_ID, {3'b000, m_isread, m_addr}});
            if (!m_isread)
                for (int i = 0; i < 4; i++)
                    m_q.push_back('{SLOT_WRITEDATA, C_ID, m_wdata[32*i +: 32]});
            m_q.push_back('{SLOT_TOKEN, 4'd0, 32'd0});
            s = m_q.pop_front();
            e_type = s.t; e_src = s.s; e_ring = s.d;
            m_hold = 1;
        end else begin
            e_type = SlotTypeIn; e_src = SourceIn; e_ring = RingIn;
        end
        if (RDdest == C_ID) begin
            if (rd_pre) m_words.push_back(RDreturn);
            else        e_err = 1;
        end
        if (rd_pre) begin
            if (m_words.size() == 4) begin
                e_rsp_valid = 1;
                e_rsp_data  = {m_words[3], m_words[2], m_words[1], m_words[0]};
                m_pend = 0; m_rd_active = 0;
            end else begin
                m_tmo++;
                if (m_tmo == C_TO) begin
                    e_err = 1; m_pend = 0; m_rd_active = 0;
                end
            end
        end
        if (ready_pre && req_valid) begin
            m_pend = 1; m_isread = !req_write; m_addr = req_addr; m_wdata = req_wdata;
        end
        e_ready = !m_pend;
    endtask

    task automatic compare_all();
        chk("ring_data", RingOut, e_ring);
        chk("slot_type", SlotTypeOut, e_type);
        chk("slot_src", SourceOut, e_src);
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("err", err, e_err);
        if (e_rsp_valid) chk("rsp_data", rsp_data, e_rsp_data);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic set_null();
        SlotTypeIn = SLOT_NULL; SourceIn = '0; RingIn = '0;
        RDdest = 4'd0; RDreturn = '0; req_valid = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    task automatic issue(input bit wr, input logic [27:0] a, input logic [127:0] d);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
        cycle();
        req_valid = 0;
    endtask

    task automatic rand_slot();
        int r = int'($urandom % 10);
        SlotTypeIn = (r < 5) ? SLOT_NULL : (r < 7) ? SLOT_TOKEN : 4'(2 + $urandom % 4);
        SourceIn   = 4'($urandom);
        RingIn     = $urandom;
    endtask

    logic [31:0] w_a, w_b, w_c, w_d;

    initial begin
        set_null();
        do_reset();
        chk("reset_ready_low", req_ready, 1'b0);
        cycle();
        chk("ready_after_reset", req_ready, 1'b1);

        // Line write
        issue(1'b1, 28'h0001234, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
        cycle();
        SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd7; RingIn = 32'h5A5A5A5A;
        cycle();
        set_null();
        chk("wr_addr_type", SlotTypeOut, SLOT_ADDRESS);
        chk("wr_addr_word", RingOut, 32'h00001234);
        chk("wr_addr_src", SourceOut, C_ID);
        cycle(); chk("wr_wd0", RingOut, 32'hAAAA0000);
        cycle(); chk("wr_wd1", RingOut, 32'hBBBB0001);
        cycle(); chk("wr_wd2", RingOut, 32'hCCCC0002);
        cycle(); chk("wr_wd3", RingOut, 32'hDDDD0003);
        chk("wr_wd3_type", SlotTypeOut, SLOT_WRITEDATA);
        cycle(); chk("wr_token", SlotTypeOut, SLOT_TOKEN);
        chk("wr_token_data", RingOut, 32'h0);
        cycle(); chk("wr_ready_back", req_ready, 1'b1);

        // Read with interleaved foreign read-returns
        issue(1'b0, 28'h0000040, '0);
        SlotTypeIn = SLOT_TOKEN;
        cycle();
        set_null();
        chk("rd_addr_word", RingOut, 32'h10000040);
        cycle(); chk("rd_token", SlotTypeOut, SLOT_TOKEN);
        cycle();
        w_a = $urandom; w_b = $urandom; w_c = $urandom; w_d = $urandom;
        for (int i = 0; i < 4; i++) begin
            RDdest = 4'd5; RDreturn = $urandom;
            cycle();
            RDdest = C_ID;
            RDreturn = (i == 0) ? w_a : (i == 1) ? w_b : (i == 2) ? w_c : w_d;
            cycle();
        end
        set_null();
        chk("rd_pulse", rsp_valid, 1'b1);
        chk("rd_line", rsp_data, {w_d, w_c, w_b, w_a});
        cycle(); chk("rd_pulse_one", rsp_valid, 1'b0);

        // Idle pass-through, tokens included
        for (int i = 0; i < 200; i++) begin
            rand_slot();
            RDdest = 4'($urandom_range(2, 15));
            cycle();
        end
        set_null();
        chk("pass_no_err", err, 1'b0);

        // Foreign slot while WriteData is being emitted
        issue(1'b1, 28'hABCDEF0, {$urandom, $urandom, $urandom, $urandom});
        SlotTypeIn = SLOT_TOKEN;
        cycle(); set_null();
        cycle();
        SlotTypeIn = SLOT_DMCDATA; RingIn = 32'h12345678;
        cycle(); set_null();
        repeat (4) cycle();
        chk("proto_err", err, 1'b1);

        // Reset while emitting the third WriteData word
        do_reset();
        cycle();
        issue(1'b1, 28'h0000100, {$urandom, $urandom, $urandom, $urandom});
        SlotTypeIn = SLOT_TOKEN;
        cycle(); set_null();
        repeat (3) cycle();
        do_reset();
        chk("mid_reset_type", SlotTypeOut, SLOT_NULL);
        cycle();
        chk("mid_reset_ready", req_ready, 1'b1);
        chk("mid_reset_err", err, 1'b0);

        // Random mixed traffic
        for (int i = 0; i < 600; i++) begin
            rand_slot();
            req_valid = ($urandom % 4) == 0;
            req_write = $urandom % 2;
            req_addr  = 28'($urandom);
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            RDdest    = (($urandom % 3) == 0) ? C_ID : 4'($urandom_range(2, 15));
            RDreturn  = $urandom;
            cycle();
        end
        set_null();

        // Read timeout followed by a late return word
        do_reset();
        cycle();
        issue(1'b0, 28'h0000200, '0);
        SlotTypeIn = SLOT_TOKEN;
        cycle(); set_null();
        for (int i = 0; i < C_TO + 4; i++) cycle();
        chk("tmo_err", err, 1'b1);
        chk("tmo_idle", req_ready, 1'b1);
        RDdest = C_ID; RDreturn = 32'hFEEDBEEF;
        cycle(); set_null();
        chk("late_no_rsp", rsp_valid, 1'b0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ring_mem_requester.md
Name: ring_mem_requester

Overview:
- Ring station that initiates memory operations toward the ring memory controller on behalf of one core-side client.
- Captures one request at a time (read or 128-bit line write) and waits for the token. When the token arrives, it replaces it with an Address slot, plus four WriteData slots for a write, then re-emits the token.
- Read data comes back on the separate read-return path (RDreturn/RDdest). The block collects four words tagged with its ID and delivers the 128-bit line to the client.

Parameters:
- CORE_ID, 4'd1, ring source ID of this station; must be nonzero, because source 0 is nullified by the controller.
- RD_TIMEOUT, 1024, cycles in WAIT_RD before the timeout error flag is set.

Ports:
- clock  in  1  ring clock
- reset  in  1  asynchronous, active-low reset
- RingIn  in  32  ring data from upstream
- SlotTypeIn  in  4  slot type from upstream
- SourceIn  in  4  slot source from upstream
- RingOut  out  32  ring data to downstream (registered)
- SlotTypeOut  out  4  slot type to downstream (registered)
- SourceOut  out  4  slot source to downstream (registered)
- RDreturn  in  32  read-return data word
- RDdest  in  4  read-return destination ID; the word is valid for this station when RDdest == CORE_ID
- req_valid  in  1  client request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  28  line address
- req_wdata  in  128  write line; word0 = bits [31:0]
- rsp_valid  out  1  one-cycle pulse, read line valid
- rsp_data  out  128  read line; word0 = bits [31:0]
- err  out  1  sticky protocol or timeout error

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - Ring outputs become Null / 32'b0 / 4'b0.
  - req_ready = 0 while reset is asserted, then 1 in IDLE.
  - rsp_valid = 0, rsp_data = 0, err = 0.
  - Word counters = 0. Any pending request is dropped.
- Pass-through:
  - In every state except SEND_ADDR, SEND_WD and RELEASE, the outputs are register copies of the inputs.
  - Latency is 1 cycle.
- Address word format: [31] = 0, [30:29] = 0, [28] = read flag, [27:0] = req_addr. SourceOut = CORE_ID.
- States:
  - IDLE:
    - req_ready = 1.
    - On req_valid, latch write flag, address and data, then go to WAIT_TOKEN.
  - WAIT_TOKEN:
    - req_ready = 0.
    - When SlotTypeIn == Token, the token is consumed (it is not passed through) and the next state is SEND_ADDR.
  - SEND_ADDR:
    - Outputs register the Address slot one cycle after the token was sampled.
    - Write: go to SEND_WD with wcnt = 0. Read: go to RELEASE.
  - SEND_WD:
    - Emit WriteData slot word[wcnt], source CORE_ID, on 4 consecutive cycles; wcnt increments 0 to 3.
    - After wcnt == 3, go to RELEASE.
  - RELEASE:
    - Emit Token with data 0 and source 0.
    - Write: go to IDLE. Read: go to WAIT_RD with rcnt = 0 and the timeout counter cleared.
  - WAIT_RD:
    - Ring is in pass-through.
    - On each cycle with RDdest == CORE_ID, store RDreturn into word[rcnt] and increment rcnt.
    - On the 4th word, rsp_valid = 1 for the next cycle, rsp_data holds the full line, and the state returns to IDLE.
- Token-hold error:
  - During SEND_ADDR, SEND_WD and RELEASE the station holds the token, so every incoming slot must be Null.
  - Any non-Null incoming slot in those states sets err; that slot is discarded.
- Read-return outside WAIT_RD: a word with RDdest == CORE_ID arriving outside WAIT_RD sets err and is ignored.
- Timeout: if WAIT_RD exceeds RD_TIMEOUT cycles, set err and return to IDLE without asserting rsp_valid.
- Boundary cases:
  - Token arriving in IDLE or WAIT_RD is passed through unchanged.
  - A request and a token in the same cycle in IDLE: the request is latched, and that token is passed on (the request waits for the next token).
  - Reset mid-burst: the token is lost. Token regeneration is the memory controller's responsibility.
- Throughput: a write occupies the token for 6 slots (Address, 4 WriteData, Token). A read occupies it for 2 slots.
- err clears only on reset.

Decomposition:
- Shared package / defines file:
  - Slot-type constants: Null, Token, Address, WriteData, DMCAddress, DMCData, same encodings as the memory controller.
  - Address-word field positions: READ_BIT = 28, ADDR_MSB = 27.
  - Line width 128 and WORDS_PER_LINE = 4.
- No sub-module needed. An optional line_assembler (4×32 to 128 shift/collect) may be factored out for reuse by other ring clients.

Test Plan:
1. Write: req addr 0x0001234, wdata {D3,D2,D1,D0}, token at cycle t → t+1 Address 0x00001234 src CORE_ID; t+2..t+5 WriteData D0..D3; t+6 Token; req_ready high at t+7.
2. Read: req addr 0x0000040, token at t → t+1 Address 0x10000040; t+2 Token. Then RDreturn words A,B,C,D with RDdest = CORE_ID, interleaved with RDdest = other IDs → rsp_valid single pulse, rsp_data = {D,C,B,A}.
3. Pass-through: in IDLE, drive random slots including Token → outputs equal inputs delayed 1 cycle; no err.
4. Protocol error: non-Null slot arrives during SEND_WD → err = 1 and stays high; sequence still completes and Token is emitted.
5. Reset mid-operation: assert reset during SEND_WD word 2 → outputs Null/0 immediately; after release state = IDLE, req_ready = 1, no rsp_valid.
6. Timeout: read issued, no RDreturn for RD_TIMEOUT cycles → err = 1, back to IDLE, rsp_valid never asserted; a late word with RDdest = CORE_ID is ignored.
